pe_border_ur: RTL and testbench

Parametrised unary-rate border processing element for the systolic array's left edge. It accepts binary two's-complement activations and stationary sign-magnitude weights, and generates rate-coded bitstreams internally. Its own cycle counter runs a programmable-length MAC, so `mac_done` is no longer supplied externally. On completion it folds a signed partial product into the incoming partial sum, with optional saturation, and forwards operands and control to the neighbouring PE.

---
 rtl/pe_ur_pkg.sv | 40 ++++
 rtl/ur_streamgen.sv | 29 ++
 rtl/pe_border_ur.sv | 117 +++++++++++
 tb/tb_pe_border_ur.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pe_ur_pkg.sv
// Shared types and helpers for the unary-rate border PE: FSM states, bit
// reversal, magnitude clamping and saturating add on wide scratch values.
package pe_ur_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int FW = 32;

    // Reverse the low k bits of value; bits at k and above come back as 0.
    function automatic logic [FW-1:0] bitrev(input logic [FW-1:0] value, input int k);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < FW; i++)
            if (i < k) r[k-1-i] = value[i];
        return r;
    endfunction

    function automatic logic [FW-1:0] abs_clamp(input logic signed [FW-1:0] v, input int m);
        logic [FW-1:0] a;
        logic [FW-1:0] lim;
        a   = v[FW-1] ? $unsigned(-v) : $unsigned(v);
        lim = (FW'(1) << m) - FW'(1);
        return (a > lim) ? lim : a;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input bit sat, input int ow);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (sat && s > hi) s = hi;
        if (sat && s < lo) s = lo;
        return s;
    endfunction

endpackage

// File: rtl/ur_streamgen.sv
// Combinational rate-coded stream generator: compares each magnitude against
// a counter-derived threshold and ANDs the two resulting bits.
module ur_streamgen
    import pe_ur_pkg::*;
#(
    parameter int IWIDTH = 8,
    localparam int M  = IWIDTH - 1,
    localparam int KW = $clog2(IWIDTH)
) (
    input  logic [M-1:0]  ctr,
    input  logic [KW-1:0] k,
    input  logic [M-1:0]  wght_abs,
    input  logic [M-1:0]  ifm_abs,
    output logic [M-1:0]  rnd_w,
    output logic [M-1:0]  rnd_i,
    output logic          prod
);
    logic [FW-1:0] rev;

    // The weight sees a linear ramp and the activation a bit-reversed one,
    // so the two streams stay decorrelated over the whole 2^k window.
    always_comb begin
        rev   = bitrev(FW'(ctr), int'(k));
        rnd_w = ctr << (M - int'(k));
        rnd_i = rev[M-1:0] << (M - int'(k));
        prod  = (wght_abs > rnd_w) & (ifm_abs > rnd_i);
    end

endmodule

// File: rtl/pe_border_ur.sv
// Left-edge unary-rate PE: runs a 2^k-cycle rate-coded MAC and folds the
// signed result into the upstream partial sum on completion.
module pe_border_ur
    import pe_ur_pkg::*;
#(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 16,
    parameter int SAT    = 1,
    localparam int M  = IWIDTH - 1,
    localparam int KW = $clog2(IWIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [KW-1:0]            cycle_log,
    input  logic signed [IWIDTH-1:0] ifm,
    input  logic                     en_w,
    input  logic                     clr_w,
    input  logic                     wght_sign,
    input  logic [M-1:0]             wght_abs,
    input  logic                     clr_o,
    input  logic signed [OWIDTH-1:0] ofm,
    output logic                     busy,
    output logic                     done,
    output logic                     start_d,
    output logic                     ifm_sign_d,
    output logic [M-1:0]             ifm_abs_d,
    output logic                     wght_sign_d,
    output logic [M-1:0]             wght_abs_d,
    output logic signed [OWIDTH-1:0] ofm_d
);
    state_t             state, nstate;
    logic [M-1:0]       ctr;
    logic [M-1:0]       last_ctr;
    logic [KW-1:0]      k_q;
    logic [M:0]         partial, partial_nx, inc;
    logic [M-1:0]       rnd_w, rnd_i;
    logic               prod, accept, last;
    logic signed [63:0] delta, sum;

    ur_streamgen #(.IWIDTH(IWIDTH)) u_gen (
        .ctr(ctr), .k(k_q), .wght_abs(wght_abs_d), .ifm_abs(ifm_abs_d),
        .rnd_w(rnd_w), .rnd_i(rnd_i), .prod(prod)
    );

    assign accept   = (state == IDLE) && start && !clr_o;
    assign last_ctr = ~({M{1'b1}} << k_q);
    assign last     = (state == RUN) && (ctr == last_ctr);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // Each hit is worth 2^(M-k), so a full window saturates at exactly 2^M.
    always_comb begin
        inc        = prod ? ((M+1)'(1) << (M - int'(k_q))) : '0;
        partial_nx = partial + inc;
        delta      = $signed(64'(partial_nx));
        if (ifm_sign_d ^ wght_sign_d) delta = -delta;
        sum        = sat_add(64'(ofm), delta, SAT != 0, OWIDTH);
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (ctr == last_ctr) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (clr_o) nstate = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ctr        <= '0;
            k_q        <= '0;
            partial    <= '0;
            start_d    <= 1'b0;
            ifm_sign_d <= 1'b0;
            ifm_abs_d  <= '0;
            ofm_d      <= '0;
        end else begin
            state   <= nstate;
            start_d <= accept;
            if (accept) begin
                ifm_sign_d <= ifm[IWIDTH-1];
                ifm_abs_d  <= M'(abs_clamp(FW'(ifm), M));
                k_q        <= (cycle_log > KW'(M)) ? KW'(M) : cycle_log;
                ctr        <= '0;
                partial    <= '0;
            end else if (state == RUN) begin
                ctr     <= ctr + M'(1);
                partial <= partial_nx;
            end
            if (clr_o) begin
                partial <= '0;
                ofm_d   <= '0;
            end else if (last) begin
                ofm_d <= OWIDTH'(sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wght_sign_d <= 1'b0;
            wght_abs_d  <= '0;
        end else if (clr_w) begin
            wght_sign_d <= 1'b0;
            wght_abs_d  <= '0;
        end else if (en_w) begin
            wght_sign_d <= wght_sign;
            wght_abs_d  <= wght_abs;
        end
    end

endmodule

// File: tb/tb_pe_border_ur.sv
// Directed bench for pe_border_ur: a saturating and a wrapping instance share
// every input; expected latencies and sums are hand-computed constants.
module tb_pe_border_ur;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        cycle_log = '0;
    logic signed [7:0] ifm = '0;
    logic              en_w = 1'b0, clr_w = 1'b0, wght_sign = 1'b0;
    logic [6:0]        wght_abs = '0;
    logic              clr_o = 1'b0;
    logic signed [15:0] ofm = '0;

    logic busy, done, start_d, ifm_sign_d, wght_sign_d;
    logic [6:0] ifm_abs_d, wght_abs_d;
    logic signed [15:0] ofm_d;
    logic busy0, done0, start_d0, ifm_sign_d0, wght_sign_d0;
    logic [6:0] ifm_abs_d0, wght_abs_d0;
    logic signed [15:0] ofm_d0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_border_ur #(.IWIDTH(8), .OWIDTH(16), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cycle_log(cycle_log), .ifm(ifm),
        .en_w(en_w), .clr_w(clr_w), .wght_sign(wght_sign), .wght_abs(wght_abs),
        .clr_o(clr_o), .ofm(ofm), .busy(busy), .done(done), .start_d(start_d),
        .ifm_sign_d(ifm_sign_d), .ifm_abs_d(ifm_abs_d), .wght_sign_d(wght_sign_d),
        .wght_abs_d(wght_abs_d), .ofm_d(ofm_d));

    pe_border_ur #(.IWIDTH(8), .OWIDTH(16), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .cycle_log(cycle_log), .ifm(ifm),
        .en_w(en_w), .clr_w(clr_w), .wght_sign(wght_sign), .wght_abs(wght_abs),
        .clr_o(clr_o), .ofm(ofm), .busy(busy0), .done(done0), .start_d(start_d0),
        .ifm_sign_d(ifm_sign_d0), .ifm_abs_d(ifm_abs_d0), .wght_sign_d(wght_sign_d0),
        .wght_abs_d(wght_abs_d0), .ofm_d(ofm_d0));

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic s, input logic [6:0] a);
        wght_sign = s; wght_abs = a; en_w = 1'b1;
        step();
        en_w = 1'b0;
        chk("wght_abs_d", 32'(wght_abs_d), 32'(a));
    endtask

    // Pulse start, then count cycles until done (cycle after start = 1).
    task automatic mac(input string tag, input logic signed [7:0] a, input logic [2:0] k,
                       input logic signed [15:0] o, input int exp_lat,
                       input int exp1, input int exp0);
        int n;
        ifm = a; cycle_log = k; ofm = o; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, ".start_d"}, 32'(start_d), 1);
        n = 1;
        while (!done && n < 400) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".ofm_d"}, 32'(ofm_d), exp1);
        chk({tag, ".ofm_d_wrap"}, 32'(ofm_d0), exp0);
        step();
        chk({tag, ".done_low"}, 32'(done), 0);
    endtask

    initial begin
        int n;
        int seen;
        step(); step();
        chk("rst.ofm_d", 32'(ofm_d), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.start_d", 32'(start_d), 0);
        rst_n = 1'b1;
        step();

        // Weight register: clear wins over load.
        wght_abs = 7'd50; en_w = 1'b1; clr_w = 1'b1;
        step();
        en_w = 1'b0; clr_w = 1'b0;
        chk("clr_w_wins", 32'(wght_abs_d), 0);

        set_w(1'b0, 7'd64);
        mac("m64", 8'sd64, 3'd7, 16'sd0, 129, 32, 32);

        set_w(1'b0, 7'd127);
        mac("neg", -8'sd128, 3'd7, 16'sd1000, 129, 873, 873);
        chk("neg.ifm_abs_d", 32'(ifm_abs_d), 127);
        chk("neg.ifm_sign_d", 32'(ifm_sign_d), 1);

        // k=3 with an ignored start during RUN cycle 4.
        set_w(1'b0, 7'd64);
        ifm = 8'sd64; cycle_log = 3'd3; ofm = 16'sd0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        ifm = -8'sd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("k3.ignored_start_d", 32'(start_d), 0);
        chk("k3.ifm_abs_hold", 32'(ifm_abs_d), 64);
        n = 5;
        while (!done && n < 400) begin
            step();
            n++;
        end
        chk("k3.latency", n, 9);
        chk("k3.ofm_d", 32'(ofm_d), 32);
        step();

        set_w(1'b0, 7'd127);
        mac("sat", 8'sd127, 3'd7, 16'sd32760, 129, 32767, -32649);

        set_w(1'b0, 7'd1);
        mac("k0", -8'sd3, 3'd0, 16'sd100, 2, -28, -28);

        // Abort at RUN cycle 50, then restart on the following cycle.
        set_w(1'b0, 7'd64);
        mac("pre", 8'sd64, 3'd7, 16'sd500, 129, 532, 532);
        ifm = 8'sd64; cycle_log = 3'd7; ofm = 16'sd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 50; i++) step();
        chk("clr.busy_before", 32'(busy), 1);
        clr_o = 1'b1;
        step();
        clr_o = 1'b0;
        chk("clr.ofm_d", 32'(ofm_d), 0);
        chk("clr.busy", 32'(busy), 0);
        chk("clr.done", 32'(done), 0);
        mac("after_clr", 8'sd64, 3'd7, 16'sd0, 129, 32, 32);

        // Asynchronous reset in the middle of a run.
        ifm = 8'sd64; cycle_log = 3'd7; ofm = 16'sd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        chk("arst.ofm_d", 32'(ofm_d), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.ifm_abs_d", 32'(ifm_abs_d), 0);
        chk("arst.wght_abs_d", 32'(wght_abs_d), 0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 140; i++) begin
            step();
            if (busy || done) seen = 1;
        end
        chk("arst.idle_after", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
